rr_grant_arbiter: RTL

- Parametrised, registered N-way arbiter for the mux subsystem.
- Generalises the 8-bit combinational trailing/leading-zero grant encoder to any WIDTH.
- Adds round-robin fairness, a valid/ack grant handshake and multi-beat grant locking.
- Sits in front of a shared resource (mux output, bus port): picks one requester, holds the grant until the consumer acknowledges, then rotates priority.

---
 rtl/mux_pkg.sv | 18 +
 rtl/prio_search.sv | 37 +++
 rtl/rr_grant_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the mux-subsystem grant arbiter.
package mux_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   // Encoded index width; a single requester still gets a 1-bit index.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_search.sv
// Circular first-set-bit search starting at 'start', wrapping from WIDTH-1 to 0.
module prio_search #(
   parameter int WIDTH       = 8,
   parameter int COUNT_WIDTH = 3
) (
   input  logic [WIDTH-1:0]       req,
   input  logic [COUNT_WIDTH-1:0] start,
   output logic                   found,
   output logic [COUNT_WIDTH-1:0] idx
);

   logic [2*WIDTH-1:0] dbl;
   logic [2*WIDTH-1:0] masked;

   assign dbl = {req, req};

   // Bits below 'start' in the low copy are masked; the high copy supplies the wrap.
   always_comb begin
      masked = '0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         masked[i] = dbl[i] & (i >= int'(start));
      end
   end

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 2*WIDTH-1; i >= 0; i--) begin
         if (masked[i]) begin
            found = 1'b1;
            if (i >= WIDTH) idx = COUNT_WIDTH'(i - WIDTH);
            else            idx = COUNT_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered N-way arbiter with valid/ack handshake, multi-beat locking and
// round-robin or fixed-priority selection.
//
// state  | meaning
// IDLE   | no grant active, waiting for any request
// GRANT  | grant presented, waiting for ack
// LOCKED | grant re-held by ack+lock, waiting for the next ack
module rr_grant_arbiter
   import mux_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int MODE        = MODE_RR,
   parameter int COUNT_WIDTH = clog2_min1(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_req,
   input  logic                   in_ack,
   input  logic                   in_lock,
   output logic [COUNT_WIDTH-1:0] o_grant,
   output logic [WIDTH-1:0]       o_grant_onehot,
   output logic                   o_valid,
   output logic                   o_empty
);

   localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(WIDTH - 1);

   state_t                 state, state_nxt;
   logic [COUNT_WIDTH-1:0] ptr, ptr_nxt, ptr_rel, search_ptr;
   logic [COUNT_WIDTH-1:0] grant_nxt, found_idx;
   logic [WIDTH-1:0]       onehot_nxt;
   logic                   valid_nxt, found, release_now;

   assign release_now = (state != IDLE) && in_ack && !in_lock;
   assign ptr_rel     = (o_grant == LAST_IDX) ? '0 : o_grant + COUNT_WIDTH'(1);
   // On release the search already uses the advanced pointer, giving back-to-back grants.
   assign search_ptr  = release_now ? ptr_rel : ptr;

   generate
      if (MODE == MODE_FIXED) begin : g_fixed
         prio_search #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_search (
            .req   (in_req),
            .start ('0),
            .found (found),
            .idx   (found_idx)
         );
      end else begin : g_rr
         prio_search #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_search (
            .req   (in_req),
            .start (search_ptr),
            .found (found),
            .idx   (found_idx)
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = o_grant;
      valid_nxt = o_valid;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               valid_nxt = 1'b1;
               grant_nxt = found_idx;
            end
         end
         GRANT, LOCKED: begin
            if (in_ack && in_lock) begin
               state_nxt = LOCKED;
            end else if (release_now) begin
               ptr_nxt = ptr_rel;
               if (found) begin
                  state_nxt = GRANT;
                  grant_nxt = found_idx;
               end else begin
                  state_nxt = IDLE;
                  valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
      onehot_nxt = valid_nxt ? (WIDTH'(1) << grant_nxt) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         ptr            <= '0;
         o_grant        <= '0;
         o_grant_onehot <= '0;
         o_valid        <= 1'b0;
         o_empty        <= 1'b1;
      end else begin
         state          <= state_nxt;
         ptr            <= ptr_nxt;
         o_grant        <= grant_nxt;
         o_grant_onehot <= onehot_nxt;
         o_valid        <= valid_nxt;
         o_empty        <= ~|in_req;
      end
   end

endmodule
